timer_multi_ch: RTL and testbench

Parametrised multi-channel timer: NUM_CH independent counters sharing one programmable prescaler. Each channel runs one-shot or periodic, counting down or up, with a sticky interrupt flag. It generalises the single-channel one-shot countdown into the timer subsystem's main block. The register/bus wrapper drives its configuration and trigger strobes and collects its interrupts.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_channel.sv | 113 +++++++++++
 rtl/timer_multi_ch.sv | 73 +++++++
 tb/tb_timer_multi_ch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and types for the multi-channel timer: mode-bit positions,
// channel FSM states and default widths.
package timer_pkg;

    localparam int MODE_PERIODIC_BIT = 0;
    localparam int MODE_UP_BIT       = 1;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_PRE_W  = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM, up/down counter with latched load value and
// mode, registered expiry pulse and sticky interrupt flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             en,
    input  logic             trig,
    input  logic             reload,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic [1:0]       cfg_mode,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             running,
    output logic             expire,
    output logic             irq
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic [1:0]       mode_q, mode_d;
    logic             expire_q, expire_d;
    logic             irq_q, irq_d;
    logic             up_s;
    logic             term_s;

    assign up_s   = mode_q[MODE_UP_BIT];
    // Terminal compare happens before any step, so the counter can never wrap.
    assign term_s = up_s ? (cnt_q == ld_q) : (cnt_q == {WIDTH{1'b0}});

    // Next-state logic: reload beats trig, trig beats a tick (and its expiry).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_d     = ld_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        if (reload) begin
            state_d = ST_IDLE;
            if (cfg_mode[MODE_UP_BIT]) begin
                cnt_d = {WIDTH{1'b0}};
            end else begin
                cnt_d = cfg_load;
            end
        end else if (trig) begin
            state_d = ST_RUN;
            ld_d    = cfg_load;
            mode_d  = cfg_mode;
            if (cfg_mode[MODE_UP_BIT]) begin
                cnt_d = {WIDTH{1'b0}};
            end else begin
                cnt_d = cfg_load;
            end
        end else if ((state_q == ST_RUN) && tick && en) begin
            if (term_s) begin
                expire_d = 1'b1;
                if (mode_q[MODE_PERIODIC_BIT]) begin
                    cnt_d = up_s ? {WIDTH{1'b0}} : ld_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end else if (up_s) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // Sticky interrupt: a new expiry wins over a same-cycle clear.
    always_comb begin
        irq_d = irq_q;
        if (expire_d) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {WIDTH{1'b0}};
            ld_q     <= {WIDTH{1'b0}};
            mode_q   <= 2'b00;
            expire_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_q     <= ld_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
            irq_q    <= irq_d;
        end
    end

    assign cnt     = cnt_q;
    assign running = (state_q == ST_RUN);
    assign expire  = expire_q;
    assign irq     = irq_q;

endmodule

// File: rtl/timer_multi_ch.sv
// Multi-channel timer: one free-running programmable prescaler whose tick is
// shared by NUM_CH independent timer_channel instances.
module timer_multi_ch
    import timer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PRE_W  = DEF_PRE_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PRE_W-1:0]        prescale,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       trig,
    input  logic [NUM_CH-1:0]       reload,
    input  logic [NUM_CH*WIDTH-1:0] cfg_load,
    input  logic [NUM_CH*2-1:0]     cfg_mode,
    input  logic [NUM_CH-1:0]       irq_clr,
    output logic [NUM_CH*WIDTH-1:0] cnt,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       expire,
    output logic [NUM_CH-1:0]       irq
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_s;

    // Prescaler wrap; a count stranded above a lowered prescale wraps without a tick.
    always_comb begin
        tick_s    = 1'b0;
        pre_cnt_d = pre_cnt_q;
        if (pre_cnt_q == prescale) begin
            tick_s    = 1'b1;
            pre_cnt_d = {PRE_W{1'b0}};
        end else if (pre_cnt_q > prescale) begin
            tick_s    = 1'b0;
            pre_cnt_d = {PRE_W{1'b0}};
        end else begin
            tick_s    = 1'b0;
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick_s),
            .en       (en[i]),
            .trig     (trig[i]),
            .reload   (reload[i]),
            .cfg_load (cfg_load[i*WIDTH +: WIDTH]),
            .cfg_mode (cfg_mode[i*2 +: 2]),
            .irq_clr  (irq_clr[i]),
            .cnt      (cnt[i*WIDTH +: WIDTH]),
            .running  (running[i]),
            .expire   (expire[i]),
            .irq      (irq[i])
        );
    end

endmodule

// File: tb/tb_timer_multi_ch.sv
// Directed self-checking bench for timer_multi_ch: a 4x32-bit instance for the
// main scenarios and a 1x8-bit instance for the full-range up count.
module tb_timer_multi_ch;

    localparam int W  = 32;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      prescale;
    logic [NC-1:0]   en, trig, reload, irq_clr;
    logic [NC*W-1:0] cfg_load;
    logic [NC*2-1:0] cfg_mode;
    logic [NC*W-1:0] cnt;
    logic [NC-1:0]   running, expire, irq;

    logic [7:0] prescale8;
    logic [0:0] en8, trig8, reload8, irq_clr8, running8, expire8, irq8;
    logic [7:0] cfg_load8, cnt8;
    logic [1:0] cfg_mode8;

    int n_checks = 0;
    int n_errors = 0;

    timer_multi_ch #(.WIDTH(W), .NUM_CH(NC), .PRE_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .prescale(prescale), .en(en), .trig(trig),
        .reload(reload), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .irq_clr(irq_clr),
        .cnt(cnt), .running(running), .expire(expire), .irq(irq)
    );

    timer_multi_ch #(.WIDTH(8), .NUM_CH(1), .PRE_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .prescale(prescale8), .en(en8), .trig(trig8),
        .reload(reload8), .cfg_load(cfg_load8), .cfg_mode(cfg_mode8), .irq_clr(irq_clr8),
        .cnt(cnt8), .running(running8), .expire(expire8), .irq(irq8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ch, input logic [31:0] ld, input logic [1:0] mode);
        cfg_load[ch*W +: W] = ld;
        cfg_mode[ch*2 +: 2] = mode;
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return cnt[ch*W +: W];
    endfunction

    // Concurrent-channel expectations, index k = edges after the trig edge.
    logic [31:0] c_exp [5][4];
    logic [3:0]  x_exp [5];
    logic [3:0]  r_exp [5];

    initial begin
        c_exp[0] = '{32'd1, 32'd0, 32'd3, 32'd0};
        c_exp[1] = '{32'd0, 32'd1, 32'd2, 32'd0};
        c_exp[2] = '{32'd1, 32'd2, 32'd1, 32'd0};
        c_exp[3] = '{32'd0, 32'd2, 32'd0, 32'd0};
        c_exp[4] = '{32'd1, 32'd2, 32'd0, 32'd0};
        x_exp    = '{4'b0000, 4'b1000, 4'b1001, 4'b1010, 4'b1101};
        r_exp    = '{4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1001};

        rst_n = 1'b0; prescale = 8'd2; en = 4'hF; trig = 4'h0; reload = 4'h0;
        irq_clr = 4'h0; cfg_load = '0; cfg_mode = '0;
        prescale8 = 8'd0; en8 = 1'b1; trig8 = 1'b0; reload8 = 1'b0; irq_clr8 = 1'b0;
        cfg_load8 = 8'd0; cfg_mode8 = 2'b00;

        step();
        check("rst_cnt", cnt, 64'd0);
        check("rst_running", running, 64'd0);
        check("rst_expire", expire, 64'd0);
        check("rst_irq", irq, 64'd0);
        rst_n = 1'b1;

        // Up periodic ld=1, prescale=2: ticks land on edges 3,6,9,12 after reset release.
        set_cfg(1, 32'd1, 2'b11);
        trig = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            irq_clr = (k == 8 || k == 12) ? 4'b0010 : 4'b0000;
            step();
            trig = 4'h0;
            check($sformatf("up_cnt_k%0d", k), cnt_of(1), ((k % 6) >= 3) ? 64'd1 : 64'd0);
            check($sformatf("up_exp_k%0d", k), expire[1], (k % 6 == 0) ? 64'd1 : 64'd0);
            check($sformatf("up_irq_k%0d", k), irq[1],
                  (k == 6 || k == 7 || k == 12) ? 64'd1 : 64'd0);
        end
        irq_clr = 4'h0;
        reload = 4'b0010;
        step();
        reload = 4'h0;
        check("up_stop_run", running[1], 64'd0);
        check("up_stop_cnt", cnt_of(1), 64'd0);
        prescale = 8'd0;
        step();

        // Down one-shot ld=3 with a tick every cycle.
        set_cfg(0, 32'd3, 2'b00);
        trig = 4'b0001;
        step();
        trig = 4'h0;
        check("os_run", running[0], 64'd1);
        for (int k = 0; k <= 3; k++) begin
            if (k != 0) step();
            check($sformatf("os_cnt_k%0d", k), cnt_of(0), 64'(3 - k));
            check($sformatf("os_noexp_k%0d", k), expire[0], 64'd0);
        end
        step();
        check("os_expire", expire[0], 64'd1);
        check("os_irq", irq[0], 64'd1);
        check("os_idle", running[0], 64'd0);
        check("os_cnt_end", cnt_of(0), 64'd0);
        step();
        check("os_pulse_end", expire[0], 64'd0);
        check("os_cnt_hold", cnt_of(0), 64'd0);
        check("os_irq_sticky", irq[0], 64'd1);
        irq_clr = 4'b0001;
        step();
        irq_clr = 4'h0;
        check("os_irq_clr", irq[0], 64'd0);

        // Restart mid-count, reload abort, reload+trig together.
        set_cfg(2, 32'd10, 2'b01);
        trig = 4'b0100;
        step();
        trig = 4'h0;
        repeat (5) step();
        check("rs_cnt5", cnt_of(2), 64'd5);
        trig = 4'b0100;
        step();
        trig = 4'h0;
        check("rs_restart", cnt_of(2), 64'd10);
        check("rs_noexp", expire[2], 64'd0);
        set_cfg(2, 32'd7, 2'b01);
        reload = 4'b0100;
        step();
        reload = 4'h0;
        check("ab_idle", running[2], 64'd0);
        check("ab_cnt", cnt_of(2), 64'd7);
        check("ab_noexp", expire[2], 64'd0);
        reload = 4'b0100; trig = 4'b0100;
        step();
        reload = 4'h0; trig = 4'h0;
        check("rt_idle", running[2], 64'd0);
        check("rt_cnt", cnt_of(2), 64'd7);

        // A trig on the would-be expiry edge restarts without an expiry.
        set_cfg(2, 32'd2, 2'b01);
        trig = 4'b0100;
        step();
        trig = 4'h0;
        step(); step();
        check("sup_cnt0", cnt_of(2), 64'd0);
        trig = 4'b0100;
        step();
        trig = 4'h0;
        check("sup_cnt", cnt_of(2), 64'd2);
        check("sup_noexp", expire[2], 64'd0);
        check("sup_noirq", irq[2], 64'd0);

        // Periodic reload uses the latched value, not a changed cfg_load.
        set_cfg(2, 32'd9, 2'b01);
        step(); step();
        check("ldq_cnt0", cnt_of(2), 64'd0);
        step();
        check("ldq_expire", expire[2], 64'd1);
        check("ldq_reload", cnt_of(2), 64'd2);
        check("ldq_run", running[2], 64'd1);
        reload = 4'b0100;
        step();
        reload = 4'h0;
        check("ldq_stop", cnt_of(2), 64'd9);

        // en=0 freezes count and state for 4 cycles.
        set_cfg(3, 32'd6, 2'b00);
        trig = 4'b1000;
        step();
        trig = 4'h0;
        step(); step();
        check("en_cnt4", cnt_of(3), 64'd4);
        en = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("en_frz_cnt%0d", k), cnt_of(3), 64'd4);
            check($sformatf("en_frz_run%0d", k), running[3], 64'd1);
        end
        en = 4'hF;
        for (int k = 3; k >= 0; k--) begin
            step();
            check($sformatf("en_res_cnt%0d", k), cnt_of(3), 64'(k));
        end
        step();
        check("en_expire", expire[3], 64'd1);
        check("en_idle", running[3], 64'd0);

        // ld=0 periodic expires on every tick.
        set_cfg(0, 32'd0, 2'b01);
        trig = 4'b0001;
        step();
        trig = 4'h0;
        check("z_first", expire[0], 64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("z_exp%0d", k), expire[0], 64'd1);
            check($sformatf("z_cnt%0d", k), cnt_of(0), 64'd0);
        end
        reload = 4'b0001;
        step();
        reload = 4'h0;

        // 8-bit up one-shot to 255: 256 ticks, no overflow.
        cfg_load8 = 8'd255; cfg_mode8 = 2'b10; trig8 = 1'b1;
        step();
        trig8 = 1'b0;
        check("w8_start", cnt8, 64'd0);
        repeat (255) step();
        check("w8_cnt255", cnt8, 64'd255);
        check("w8_noexp", expire8, 64'd0);
        step();
        check("w8_expire", expire8, 64'd1);
        check("w8_idle", running8, 64'd0);
        check("w8_hold", cnt8, 64'd255);

        // Four channels in mixed modes at once.
        irq_clr = 4'hF;
        step();
        irq_clr = 4'h0;
        set_cfg(0, 32'd1, 2'b01);
        set_cfg(1, 32'd2, 2'b10);
        set_cfg(2, 32'd3, 2'b00);
        set_cfg(3, 32'd0, 2'b11);
        trig = 4'hF;
        for (int k = 0; k <= 4; k++) begin
            step();
            trig = 4'h0;
            for (int c = 0; c < 4; c++) begin
                check($sformatf("mx_cnt_k%0d_c%0d", k, c), cnt_of(c), c_exp[k][c]);
            end
            check($sformatf("mx_exp_k%0d", k), expire, x_exp[k]);
            check($sformatf("mx_run_k%0d", k), running, r_exp[k]);
        end

        // Asynchronous reset mid-run.
        #2 rst_n = 1'b0;
        #1;
        check("ar_cnt", cnt, 64'd0);
        check("ar_running", running, 64'd0);
        check("ar_expire", expire, 64'd0);
        check("ar_irq", irq, 64'd0);
        check("ar_cnt8", cnt8, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
